// File: rtl/eth_speed_pkg.sv
// ============================================================================
// Module   : eth_speed_pkg
// Purpose  : Shared speed encoding and edge-count classifier for eth_speed_detect.
// Revision : 1.0
// ============================================================================
`default_nettype none

package eth_speed_pkg;

  typedef enum logic [1:0] {
    SPEED_10M   = 2'b00,
    SPEED_100M  = 2'b01,
    SPEED_1000M = 2'b10,
    SPEED_NONE  = 2'b11
  } speed_t;

  function automatic speed_t classify(input logic [31:0] total,
                                      input int unsigned t1000,
                                      input int unsigned t100,
                                      input int unsigned t10);
    speed_t r;
    if (total >= t1000)      r = SPEED_1000M;
    else if (total >= t100)  r = SPEED_100M;
    else if (total >= t10)   r = SPEED_10M;
    else                     r = SPEED_NONE;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eth_speed_detect_chan.sv
// ============================================================================
// Module   : eth_speed_detect_chan
// Purpose  : One channel: RX toggle synchroniser, edge counter, classifier, hysteresis.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eth_speed_detect_chan
  import eth_speed_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES  = 1024,
  parameter int unsigned THRESH_1000M   = 128,
  parameter int unsigned THRESH_100M    = 24,
  parameter int unsigned THRESH_10M     = 2,
  parameter int unsigned STABLE_WINDOWS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       window_end_i,
  input  logic       rx_prescale_i,
  output logic [1:0] speed_o,
  output logic       speed_valid_o,
  output logic       mii_select_o,
  output logic       speed_change_o
);

  localparam int CNT_W = $clog2(WINDOW_CYCLES + 1);
  localparam int AGR_W = $clog2(STABLE_WINDOWS + 1);

  logic [2:0]       sync_q;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [AGR_W-1:0] agree_q, agree_d;
  speed_t           cand_q, cand_d, speed_q, speed_d, cls, cur;
  logic             valid_q, valid_d, mii_q, mii_d, chg_q, chg_d;
  logic             edge_w;
  logic [31:0]      total_w, agree_n;

  assign edge_w  = sync_q[1] ^ sync_q[2];
  // An edge landing on the window's last cycle belongs to the closing window.
  assign total_w = {{(32-CNT_W){1'b0}}, edge_cnt_q} + {31'b0, edge_w};
  assign cls     = classify(total_w, THRESH_1000M, THRESH_100M, THRESH_10M);
  assign cur     = valid_q ? speed_q : SPEED_NONE;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    cand_d     = cand_q;
    agree_d    = agree_q;
    agree_n    = 32'(agree_q);
    speed_d    = speed_q;
    valid_d    = valid_q;
    mii_d      = mii_q;
    chg_d      = 1'b0;
    if (window_end_i) begin
      edge_cnt_d = '0;
      if (cls == cur) begin
        agree_d = '0;
      end else begin
        if (cls == cand_q) begin
          agree_n = 32'(agree_q) + 32'd1;
        end else begin
          cand_d  = cls;
          agree_n = 32'd1;
        end
        if (agree_n == STABLE_WINDOWS) begin
          agree_d = '0;
          chg_d   = 1'b1;
          if (cls == SPEED_NONE) begin
            valid_d = 1'b0;
          end else begin
            speed_d = cls;
            valid_d = 1'b1;
            mii_d   = (cls != SPEED_1000M);
          end
        end else begin
          agree_d = agree_n[AGR_W-1:0];
        end
      end
    end else if (edge_w && (edge_cnt_q != CNT_W'(WINDOW_CYCLES))) begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      edge_cnt_q <= '0;
      agree_q    <= '0;
      cand_q     <= SPEED_10M;
      speed_q    <= SPEED_1000M;
      valid_q    <= 1'b0;
      mii_q      <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], rx_prescale_i};
      edge_cnt_q <= edge_cnt_d;
      agree_q    <= agree_d;
      cand_q     <= cand_d;
      speed_q    <= speed_d;
      valid_q    <= valid_d;
      mii_q      <= mii_d;
      chg_q      <= chg_d;
    end
  end

  assign speed_o        = speed_q;
  assign speed_valid_o  = valid_q;
  assign mii_select_o   = mii_q;
  assign speed_change_o = chg_q;

endmodule

`default_nettype wire

// File: rtl/eth_speed_detect.sv
// ============================================================================
// Module   : eth_speed_detect
// Purpose  : Multi-channel GMII/MII link-speed detector sharing one reference window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eth_speed_detect
  import eth_speed_pkg::*;
#(
  parameter int unsigned CHANNELS       = 1,
  parameter int unsigned WINDOW_CYCLES  = 1024,
  parameter int unsigned THRESH_1000M   = 128,
  parameter int unsigned THRESH_100M    = 24,
  parameter int unsigned THRESH_10M     = 2,
  parameter int unsigned STABLE_WINDOWS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   rx_prescale,
  output logic [2*CHANNELS-1:0] speed,
  output logic [CHANNELS-1:0]   speed_valid,
  output logic [CHANNELS-1:0]   mii_select,
  output logic [CHANNELS-1:0]   speed_change
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);

  logic [WIN_W-1:0] win_cnt_q;
  logic             window_end;

  assign window_end = (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)             win_cnt_q <= '0;
    else if (window_end) win_cnt_q <= '0;
    else                 win_cnt_q <= win_cnt_q + 1'b1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    eth_speed_detect_chan #(
      .WINDOW_CYCLES  (WINDOW_CYCLES),
      .THRESH_1000M   (THRESH_1000M),
      .THRESH_100M    (THRESH_100M),
      .THRESH_10M     (THRESH_10M),
      .STABLE_WINDOWS (STABLE_WINDOWS)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .window_end_i   (window_end),
      .rx_prescale_i  (rx_prescale[i]),
      .speed_o        (speed[2*i +: 2]),
      .speed_valid_o  (speed_valid[i]),
      .mii_select_o   (mii_select[i]),
      .speed_change_o (speed_change[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_eth_speed_detect.sv
// ============================================================================
// Module   : tb_eth_speed_detect
// Purpose  : Directed table-driven bench: two-channel detector plus a single-window-hysteresis instance.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_eth_speed_detect;

  localparam int WIN = 1024;

  typedef struct {
    int         p0, p1, nwin;
    logic [1:0] s0; logic v0, m0; int c0;
    logic [1:0] s1; logic v1, m1; int c1;
    logic [1:0] sd; logic vd, md; int cd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx0 = 1'b0;
  logic       rx1 = 1'b0;
  logic [3:0] spd;
  logic [1:0] vld, mii, chg;
  logic [1:0] spd1;
  logic       vld1, mii1, chg1;

  int per0 = 4, per1 = 20, cnt0 = 0, cnt1 = 0;
  int pc0 = 0, pc1 = 0, pcd = 0;
  int tests = 0, fails = 0;

  vec_t vec [12];
  vec_t rv;

  always #4 clk = ~clk;

  eth_speed_detect #(.CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .rx_prescale({rx1, rx0}),
    .speed(spd), .speed_valid(vld), .mii_select(mii), .speed_change(chg)
  );

  eth_speed_detect #(.CHANNELS(1), .STABLE_WINDOWS(1)) dut1 (
    .clk(clk), .rst(rst), .rx_prescale(rx0),
    .speed(spd1), .speed_valid(vld1), .mii_select(mii1), .speed_change(chg1)
  );

  // Prescaled RX clock models: toggle every perN clk cycles, held when perN == 0.
  always @(posedge clk) begin
    #2;
    if (per0 != 0) begin
      cnt0 = cnt0 + 1;
      if (cnt0 >= per0) begin cnt0 = 0; rx0 = ~rx0; end
    end
    if (per1 != 0) begin
      cnt1 = cnt1 + 1;
      if (cnt1 >= per1) begin cnt1 = 0; rx1 = ~rx1; end
    end
  end

  // Counts cycles with speed_change high; one commit per window means this equals pulse count.
  always @(negedge clk) begin
    if (chg[0]) pc0 = pc0 + 1;
    if (chg[1]) pc1 = pc1 + 1;
    if (chg1)   pcd = pcd + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_row(input int idx, input vec_t v);
    per0 = v.p0;
    per1 = v.p1;
    pc0 = 0; pc1 = 0; pcd = 0;
    repeat (v.nwin * WIN) @(posedge clk);
    @(negedge clk);
    #1;
    chk($sformatf("r%0d ch0 speed", idx), int'(spd[1:0]), int'(v.s0));
    chk($sformatf("r%0d ch0 valid", idx), int'(vld[0]),   int'(v.v0));
    chk($sformatf("r%0d ch0 mii",   idx), int'(mii[0]),   int'(v.m0));
    chk($sformatf("r%0d ch0 pulses", idx), pc0, v.c0);
    chk($sformatf("r%0d ch1 speed", idx), int'(spd[3:2]), int'(v.s1));
    chk($sformatf("r%0d ch1 valid", idx), int'(vld[1]),   int'(v.v1));
    chk($sformatf("r%0d ch1 mii",   idx), int'(mii[1]),   int'(v.m1));
    chk($sformatf("r%0d ch1 pulses", idx), pc1, v.c1);
    chk($sformatf("r%0d sw1 speed", idx), int'(spd1),     int'(v.sd));
    chk($sformatf("r%0d sw1 valid", idx), int'(vld1),     int'(v.vd));
    chk($sformatf("r%0d sw1 mii",   idx), int'(mii1),     int'(v.md));
    chk($sformatf("r%0d sw1 pulses", idx), pcd, v.cd);
  endtask

  initial begin
    //            p0   p1  nw | ch0: spd  v  m  c | ch1: spd  v  m  c | stable=1: spd v m c
    vec[0]  = '{  4,  20, 1,   2'b10, 0, 0, 0,   2'b10, 0, 0, 0,   2'b10, 1, 0, 1};
    vec[1]  = '{  4,  20, 1,   2'b10, 1, 0, 1,   2'b01, 1, 1, 1,   2'b10, 1, 0, 0};
    vec[2]  = '{  4,  20, 2,   2'b10, 1, 0, 0,   2'b01, 1, 1, 0,   2'b10, 1, 0, 0};
    vec[3]  = '{200,  20, 1,   2'b10, 1, 0, 0,   2'b01, 1, 1, 0,   2'b00, 1, 1, 1};
    vec[4]  = '{200,  20, 1,   2'b00, 1, 1, 1,   2'b01, 1, 1, 0,   2'b00, 1, 1, 0};
    vec[5]  = '{  4,  20, 1,   2'b00, 1, 1, 0,   2'b01, 1, 1, 0,   2'b10, 1, 0, 1};
    vec[6]  = '{  4,  20, 1,   2'b10, 1, 0, 1,   2'b01, 1, 1, 0,   2'b10, 1, 0, 0};
    vec[7]  = '{ 20,  20, 1,   2'b10, 1, 0, 0,   2'b01, 1, 1, 0,   2'b01, 1, 1, 1};
    vec[8]  = '{  4,  20, 2,   2'b10, 1, 0, 0,   2'b01, 1, 1, 0,   2'b10, 1, 0, 1};
    vec[9]  = '{  0,   0, 1,   2'b10, 1, 0, 0,   2'b01, 1, 1, 0,   2'b10, 0, 0, 1};
    vec[10] = '{  0,   0, 1,   2'b10, 0, 0, 1,   2'b01, 0, 1, 1,   2'b10, 0, 0, 0};
    vec[11] = '{200, 200, 2,   2'b00, 1, 1, 1,   2'b00, 1, 1, 1,   2'b00, 1, 1, 1};

    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset speed",  int'(spd), 4'b1010);
    chk("reset valid",  int'(vld), 0);
    chk("reset mii",    int'(mii), 0);
    chk("reset change", int'(chg), 0);
    release_rst();

    for (int i = 0; i < 12; i++) run_row(i, vec[i]);

    // Reset in the middle of a window, then relock from scratch.
    per0 = 4;
    per1 = 20;
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst speed",  int'(spd),  4'b1010);
    chk("midrst valid",  int'(vld),  0);
    chk("midrst mii",    int'(mii),  0);
    chk("midrst change", int'(chg),  0);
    chk("midrst sw1 valid", int'(vld1), 0);
    chk("midrst sw1 speed", int'(spd1), 2);
    release_rst();
    rv = '{4, 20, 1, 2'b10, 0, 0, 0, 2'b10, 0, 0, 0, 2'b10, 1, 0, 1};
    run_row(12, rv);
    rv = '{4, 20, 1, 2'b10, 1, 0, 1, 2'b01, 1, 1, 1, 2'b10, 1, 0, 0};
    run_row(13, rv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
